// File: rtl/eq_mac_scheduler.sv
// Sequencer that shares one pipelined MAC across NUM_BANDS FIR bands of NUM_TAPS taps each.
// Optional power-up delay-line clear: define EQ_SCHED_FLUSH_EN.
module eq_mac_scheduler #(
    parameter int NUM_BANDS = 4,
    parameter int NUM_TAPS  = 32,
    parameter int TAP_W     = 5,
    parameter int BAND_W    = 2,
    parameter int MAC_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic [23:0]             sample_in,
    output logic                    busy,
    output logic                    ovr_err,
    output logic                    dl_wr_en,
    output logic [TAP_W-1:0]        dl_wr_addr,
    output logic [23:0]             dl_wr_data,
    output logic [TAP_W-1:0]        dl_rd_addr,
    output logic [BAND_W+TAP_W-1:0] coef_addr,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic                    result_valid,
    output logic [BAND_W-1:0]       result_band
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam int DC_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);
    localparam logic [TAP_W-1:0]  TAP_MAX  = TAP_W'(NUM_TAPS - 1);
    localparam logic [BAND_W-1:0] BAND_MAX = BAND_W'(NUM_BANDS - 1);
    localparam logic [DC_W-1:0]   DC_MAX   = DC_W'(MAC_LAT - 1);

    logic [2:0]        state, state_d;
    logic [TAP_W-1:0]  wp, wp_d, k, k_d;
    logic [BAND_W-1:0] band, band_d;
    logic [DC_W-1:0]   dcnt, dcnt_d;
    logic              busy_now, ovr_d, run_d, wr_d;
    logic [TAP_W-1:0]  wr_addr_d;

    logic [MAC_LAT:0]             vld_pipe;
    logic [MAC_LAT:0][BAND_W-1:0] band_pipe;

`ifdef EQ_SCHED_FLUSH_EN
    logic flush_req;
`endif

    always_comb begin
        state_d   = state;
        wp_d      = wp;
        k_d       = k;
        band_d    = band;
        dcnt_d    = dcnt;
`ifdef EQ_SCHED_FLUSH_EN
        busy_now  = (state != S_IDLE) || flush_req;
`else
        busy_now  = (state != S_IDLE);
`endif
        case (state)
            S_IDLE: begin
`ifdef EQ_SCHED_FLUSH_EN
                if (flush_req) begin
                    state_d = S_FLUSH;
                    k_d     = '0;
                end else
`endif
                if (sample_valid) begin
                    state_d = S_WRITE;
                    wp_d    = wp + TAP_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_RUN;
                k_d     = '0;
                band_d  = '0;
            end
            S_RUN: begin
                if (k == TAP_MAX) begin
                    k_d = '0;
                    if (band == BAND_MAX) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        band_d = band + BAND_W'(1);
                    end
                end else begin
                    k_d = k + TAP_W'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt == DC_MAX) state_d = S_IDLE;
                else                dcnt_d  = dcnt + DC_W'(1);
            end
`ifdef EQ_SCHED_FLUSH_EN
            S_FLUSH: begin
                if (k == TAP_MAX) begin
                    state_d = S_IDLE;
                    wp_d    = '0;
                    k_d     = '0;
                end else begin
                    k_d = k + TAP_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        ovr_d = sample_valid && busy_now;
        run_d = (state_d == S_RUN);
        // Outputs are registered from next-state values so they line up with the state they describe.
`ifdef EQ_SCHED_FLUSH_EN
        wr_d      = (state_d == S_WRITE) || (state_d == S_FLUSH);
        wr_addr_d = (state_d == S_WRITE) ? wp_d : ((state_d == S_FLUSH) ? k_d : '0);
`else
        wr_d      = (state_d == S_WRITE);
        wr_addr_d = wr_d ? wp_d : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wp         <= '0;
            k          <= '0;
            band       <= '0;
            dcnt       <= '0;
`ifdef EQ_SCHED_FLUSH_EN
            flush_req  <= 1'b1;
`endif
            busy       <= 1'b0;
            ovr_err    <= 1'b0;
            dl_wr_en   <= 1'b0;
            dl_wr_addr <= '0;
            dl_wr_data <= '0;
            dl_rd_addr <= '0;
            coef_addr  <= '0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            vld_pipe   <= '0;
            band_pipe  <= '0;
        end else begin
            state      <= state_d;
            wp         <= wp_d;
            k          <= k_d;
            band       <= band_d;
            dcnt       <= dcnt_d;
`ifdef EQ_SCHED_FLUSH_EN
            flush_req  <= 1'b0;
`endif
            busy       <= (state_d != S_IDLE);
            ovr_err    <= ovr_d;
            dl_wr_en   <= wr_d;
            dl_wr_addr <= wr_addr_d;
            // WRITE is only ever entered from IDLE on sample_valid, so sample_in is the accepted sample.
            dl_wr_data <= (state_d == S_WRITE) ? sample_in : '0;
            dl_rd_addr <= run_d ? (wp_d - k_d) : '0;
            coef_addr  <= run_d ? {band_d, k_d} : '0;
            mac_clr    <= run_d && (k_d == '0);
            mac_en     <= run_d;
            vld_pipe[0]  <= run_d && (k_d == TAP_MAX);
            band_pipe[0] <= run_d ? band_d : '0;
            for (int i = 1; i <= MAC_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                band_pipe[i] <= band_pipe[i-1];
            end
        end
    end

    assign result_valid = vld_pipe[MAC_LAT];
    assign result_band  = band_pipe[MAC_LAT];

endmodule

// File: doc/eq_mac_scheduler.md
Name: eq_mac_scheduler

Overview:
- Controller that time-multiplexes one external pipelined 24x12 MAC across several equalizer FIR bands.
- On each accepted audio sample it:
  - writes the sample into a circular delay-line RAM;
  - walks every tap of every band, driving RAM read addresses, coefficient-ROM addresses and MAC control;
  - strobes one result-valid per band.
- Sits between the audio sample source and the shared MAC/accumulator, RAM and coefficient ROM.

Parameters:
- NUM_BANDS, 4, number of FIR bands sharing the MAC.
- NUM_TAPS, 32, taps per band; must be a power of two.
- TAP_W, 5, log2(NUM_TAPS).
- BAND_W, 2, log2(NUM_BANDS); must be at least 1.
- MAC_LAT, 2, cycles from a mac_en cycle until the MAC accumulator output reflects that tap; must be at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, new sample present
- sample_in  in  24  signed audio sample
- busy  out  1  high whenever state is not IDLE
- ovr_err  out  1  one-cycle pulse, sample_valid arrived while busy (sample dropped)
- dl_wr_en  out  1  delay RAM write enable
- dl_wr_addr  out  TAP_W  delay RAM write address
- dl_wr_data  out  24  delay RAM write data
- dl_rd_addr  out  TAP_W  delay RAM read address (RAM read is combinational)
- coef_addr  out  BAND_W+TAP_W  coefficient ROM address, formed as {band, k}
- mac_clr  out  1  first tap of a band: MAC loads the product instead of accumulating
- mac_en  out  1  MAC consumes the current RAM word and coefficient
- result_valid  out  1  one-cycle pulse, MAC output holds a finished band sum
- result_band  out  BAND_W  band index belonging to result_valid

Behaviour:
- Clock and reset:
  - Single clock domain; clock is clk.
  - Reset rst_n is asynchronous, active-low.
  - Registers reset to zero, state resets to IDLE; wp (write pointer) resets to 0.
- All outputs are registered and are 0 during and immediately after reset.
- States: IDLE, WRITE, RUN, DRAIN (plus FLUSH, see Optional Feature).
- IDLE:
  - sample_valid=1: latch sample_in, wp <= wp+1 (mod NUM_TAPS), go to WRITE.
- WRITE (1 cycle):
  - dl_wr_en=1, dl_wr_addr=wp, dl_wr_data=latched sample.
  - Clear k=0, band=0; go to RUN.
- RUN (NUM_BANDS*NUM_TAPS cycles), per cycle:
  - mac_en=1.
  - dl_rd_addr = (wp - k) mod NUM_TAPS, so k=0 is the newest sample.
  - coef_addr = {band, k}.
  - mac_clr = (k==0).
  - k increments and wraps to 0 at NUM_TAPS-1, then band increments.
  - After k=NUM_TAPS-1 of band NUM_BANDS-1, go to DRAIN.
- DRAIN (MAC_LAT cycles): mac_en=0, then go to IDLE.
- Result timing:
  - A MAC_LAT-deep shift register carries the last-tap flag and band index.
  - result_valid pulses exactly MAC_LAT cycles after the mac_en cycle with k=NUM_TAPS-1.
  - result_band equals that band.
  - Band b's result pulse may overlap band b+1's RUN cycles.
- Latency and throughput:
  - The first result_valid occurs 1+NUM_TAPS+MAC_LAT cycles after the sample_valid cycle.
  - Busy occupancy is 1+NUM_BANDS*NUM_TAPS+MAC_LAT cycles (131 at defaults).
- Overrun:
  - sample_valid while busy=1, including the sample_valid cycle itself (state not yet IDLE), is dropped.
  - ovr_err pulses the next cycle; state is unaffected.
- wp wraps from NUM_TAPS-1 to 0; read addresses wrap modulo NUM_TAPS.
- Reset asserted mid-operation:
  - Immediate return to IDLE; the result pipeline is cleared, so no stale result_valid.
  - Delay RAM contents are not cleared unless FLUSH is compiled in.

Optional Feature:
- Macro: EQ_SCHED_FLUSH_EN.
- Defined:
  - After reset release, the block enters FLUSH for NUM_TAPS cycles.
  - In FLUSH: dl_wr_en=1, dl_wr_data=0, dl_wr_addr counts 0..NUM_TAPS-1, busy=1.
  - sample_valid during FLUSH raises ovr_err.
  - Then go to IDLE with wp=0.
- Undefined: reset goes directly to IDLE; FLUSH logic is absent.

Test Plan:
- Reset, then single sample_valid with sample_in=24'h000100 at cycle 0:
  - dl_wr_en at cycle 1 with addr 1, data 0x000100.
  - RUN cycles 2..129; at cycle 2, dl_rd_addr=1, coef_addr=0, mac_clr=1.
  - result_valid at cycles 35/67/99/131 with result_band 0/1/2/3.
  - busy falls at cycle 132.
- Thirty-three samples spaced 200 cycles apart:
  - wp wraps 31->0.
  - For the sample written at addr 0, the RUN k=1 read address is 31.
- sample_valid at cycle 50 of a busy window:
  - ovr_err pulses at cycle 51, no extra write, and the result count stays at 4.
- Back-to-back sample_valid exactly 1 cycle after busy falls:
  - Accepted, no ovr_err.
- rst_n low at RUN band 2, k=10:
  - All outputs 0 asynchronously; no result_valid after release.
  - The next sample writes at addr 1.
- With EQ_SCHED_FLUSH_EN:
  - 32 zero writes to addrs 0..31 after reset, busy=1 throughout.
  - sample_valid during flush gives ovr_err.
  - The first sample after flush is accepted normally.
